loop_stack: RTL and testbench
=============================

Name: loop_stack

Overview:
- Hardware loop-context stack that sits directly upstream of the loop-check stage.
- On a loop-setup instruction it pushes a context: body start address, iteration count and loop type.
- It continuously presents the innermost context (address, counter, type) to the loop-check stage.
- It consumes loop-check's decrement and branch decision, writing the counter back on a taken loop or popping the context on exit. Supports nested loops up to DEPTH.

Parameters:
- DEPTH, 4, number of nested loop contexts held (power of two, ≥2).
- AW, 16, address width of loop start address.
- CW, 16, iteration counter width.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- push  in  1  loop-setup strobe: create new context
- push_addr  in  AW  loop body start address
- push_count  in  CW  initial iteration count
- push_type  in  2  loop type code
- upd  in  1  loop-end strobe: loop-check result valid this cycle
- upd_taken  in  1  loop-check decision: 1 = branch back, 0 = exit
- upd_counter  in  CW  decremented counter returned by loop-check
- brk  in  1  forced loop exit (break): pop innermost context
- top_valid  out  1  stack non-empty; top_* meaningful
- top_addr  out  AW  innermost start address (feeds loop-check addr)
- top_counter  out  CW  innermost counter (feeds loop-check counter_i)
- top_type  out  2  innermost type (feeds loop-check type)
- full  out  1  DEPTH contexts held
- empty  out  1  no contexts held
- level  out  $clog2(DEPTH)+1  current number of contexts
- err_ovf  out  1  sticky: push rejected while full
- err_udf  out  1  sticky: upd/brk while empty
- err_type  out  1  sticky: push with invalid type

Behaviour:
- Reset (synchronous, rst=1 at clk edge): level=0, empty=1, full=0, top_valid=0, top_addr=0, top_counter=0, top_type=0, err_* =0. Stack storage need not be cleared. Reset mid-operation discards all contexts immediately.
- top_*, full, empty, level, top_valid are functions of registered state only; no combinational path from any input. An update is visible the cycle after the edge that applies it.
- When empty, top_* are driven 0.
- Type codes: NORMAL=2'b00, E=2'b01, NE=2'b10. 2'b11 is invalid.
- Push with type 11: no state change, err_type set.
- push_count==0 is stored as 1, so the body executes once.
- upd, taken=1: top counter <= upd_counter. Address and type are unchanged.
- upd, taken=0: pop, level decrements.
- brk: pop. brk has priority over upd in the same cycle; upd is ignored.
- Pops and counter writes act on the current top first. A push in the same cycle is then applied:
  - pop+push: top entry replaced, level unchanged, no ovf even if full.
  - write+push: top counter written, then new context pushed (requires not full).
- Push while full without a same-cycle pop: rejected, err_ovf set, stack unchanged.
- upd or brk while empty: ignored, err_udf set. A valid push in the same cycle still applies.
- Error flags are sticky until rst.
- Counter arithmetic is owned by loop-check. This block stores upd_counter verbatim with no wrap checking.

Decomposition:
- Shared package/header: LOOP_NORMAL, LOOP_E, LOOP_NE, LOOP_INVALID type constants, common with loop-check; default widths AW/CW.
- One natural sub-module, loop_stack_mem: a DEPTH×(AW+CW+2) register array with one write port (index, data, enable) and a read port at top index.
- Pointer, priority and error logic stay in loop_stack.

Test Plan:
1. rst; push(addr=0x0040, count=3, type=NORMAL) → next cycle top_valid=1, top_addr=0x0040, top_counter=3, level=1.
2. From 1: upd(taken=1, counter=2), then upd(taken=1, counter=1), then upd(taken=0) → top_counter 2, 1, then empty=1, level=0, top_*=0.
3. Push 4 contexts (counts 1..4) → full=1. 5th push → err_ovf=1, level=4, top_counter=4. Same cycle upd(taken=0)+push(count=9) → level=4, top_counter=9, err_ovf stays 1 and is not newly caused.
4. Empty stack: upd=1, brk=1 → err_udf=1, level stays 0. Push type=2'b11 → err_type=1, empty stays 1.
5. Two nested contexts (outer 0x0010/5, inner 0x0020/2): brk and upd(taken=1) same cycle → inner popped, top_addr=0x0010, top_counter=5.
6. Push(count=0) → top_counter=1. Assert rst mid-operation with level=2 → next cycle level=0, top_valid=0, all err_*=0.

Source files
------------

// File: rtl/loop_stack_pkg.sv
// ---------------------------------------------------------------------------
// loop_stack_pkg
//   Constants shared between the loop-context stack and the loop-check stage.
//   - loop_type_e   : 2-bit loop type codes (NORMAL / E / NE, 11 is invalid)
//   - DEFAULT_*     : default nesting depth, address and counter widths
//   - is_valid_type : tells whether a 2-bit type code names a real loop type
// ---------------------------------------------------------------------------
package loop_stack_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int DEFAULT_AW    = 16;
  localparam int DEFAULT_CW    = 16;

  typedef enum logic [1:0] {
    LOOP_NORMAL  = 2'b00,
    LOOP_E       = 2'b01,
    LOOP_NE      = 2'b10,
    LOOP_INVALID = 2'b11
  } loop_type_e;

  // A type code is usable only if it is not the reserved encoding.
  function automatic logic is_valid_type(input logic [1:0] code);
    return code != LOOP_INVALID;
  endfunction

endpackage

// File: rtl/loop_stack_mem.sv
// ---------------------------------------------------------------------------
// loop_stack_mem
//   Register array holding the loop contexts that sit below the innermost one.
//   Storage is not reset; the owner's level counter decides which entries
//   are meaningful.
//   Ports:
//     clk     : clock, writes happen on the rising edge
//     wr_en   : write enable
//     wr_idx  : entry written when wr_en is high
//     wr_data : packed context {addr, counter, type}
//     rd_idx  : entry presented on rd_data (asynchronous read)
//     rd_data : packed context at rd_idx
// ---------------------------------------------------------------------------
module loop_stack_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 34
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [W-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] entries [DEPTH];

  // Single write port; entries are only ever overwritten, never cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      entries[wr_idx] <= wr_data;
    end
  end

  assign rd_data = entries[rd_idx];

endmodule

// File: rtl/loop_stack.sv
// ---------------------------------------------------------------------------
// loop_stack
//   Hardware loop-context stack feeding the loop-check stage. A loop-setup
//   push creates a context {start address, iteration count, type}; the
//   innermost context is presented on top_*; loop-check results either write
//   the counter back (taken) or pop the context (exit); brk forces a pop.
//   Ports:
//     clk, rst         : clock and synchronous active-high reset
//     push, push_*     : create a new context (count 0 is stored as 1)
//     upd, upd_taken,
//     upd_counter      : loop-check result for the innermost context
//     brk              : forced exit of the innermost loop (wins over upd)
//     top_valid, top_* : innermost context, all zero while empty
//     full, empty,
//     level            : occupancy
//     err_ovf/udf/type : sticky error flags, cleared only by rst
// ---------------------------------------------------------------------------
module loop_stack
  import loop_stack_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW,
  parameter int CW    = DEFAULT_CW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_addr,
  input  logic [CW-1:0]            push_count,
  input  logic [1:0]               push_type,
  input  logic                     upd,
  input  logic                     upd_taken,
  input  logic [CW-1:0]            upd_counter,
  input  logic                     brk,
  output logic                     top_valid,
  output logic [AW-1:0]            top_addr,
  output logic [CW-1:0]            top_counter,
  output logic [1:0]               top_type,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     err_ovf,
  output logic                     err_udf,
  output logic                     err_type
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;
  localparam int EW = AW + CW + 2;

  // The innermost context is kept in dedicated registers; the array only
  // holds the outer ones. That way a counter write-back plus a push in the
  // same cycle needs just one array write (spill the updated top).
  logic [LW-1:0] level_q, level_d;
  logic [AW-1:0] top_addr_q, top_addr_d;
  logic [CW-1:0] top_cnt_q, top_cnt_d;
  logic [1:0]    top_type_q, top_type_d;
  logic          err_ovf_q, err_udf_q, err_type_q;

  logic          has_top, is_full;
  logic          do_pop, do_wr, udf_evt, type_bad, push_ok, ovf_evt;
  logic [CW-1:0] new_count;

  logic          wr_en;
  logic [IW-1:0] wr_idx, rd_idx;
  logic [EW-1:0] wr_data, rd_data;

  assign has_top   = level_q != '0;
  assign is_full   = level_q == LW'(DEPTH);

  // Decode this cycle's request. brk masks upd completely, and anything
  // aimed at an empty stack is dropped and flagged.
  assign do_pop    = has_top & (brk | (upd & ~upd_taken));
  assign do_wr     = has_top & ~brk & upd & upd_taken;
  assign udf_evt   = ~has_top & (upd | brk);
  assign type_bad  = push & ~is_valid_type(push_type);
  assign push_ok   = push & ~type_bad & (do_pop | ~is_full);
  assign ovf_evt   = push & ~type_bad & ~do_pop & is_full;
  assign new_count = (push_count == '0) ? CW'(1) : push_count;

  // Spill slot is the current top's position; refill comes from the one below.
  assign wr_idx  = IW'(level_q - LW'(1));
  assign rd_idx  = IW'(level_q - LW'(2));

  loop_stack_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data)
  );

  // Next-state selection. Pop/counter-write act on the current top first,
  // then an accepted push lands on top: pop+push is an in-place replace,
  // while write+push spills the freshly written top into the array.
  always_comb begin
    level_d    = level_q;
    top_addr_d = top_addr_q;
    top_cnt_d  = top_cnt_q;
    top_type_d = top_type_q;
    wr_en      = 1'b0;
    wr_data    = {top_addr_q, (do_wr ? upd_counter : top_cnt_q), top_type_q};

    if (push_ok && do_pop) begin
      top_addr_d = push_addr;
      top_cnt_d  = new_count;
      top_type_d = push_type;
    end else if (push_ok) begin
      wr_en      = has_top;
      top_addr_d = push_addr;
      top_cnt_d  = new_count;
      top_type_d = push_type;
      level_d    = level_q + LW'(1);
    end else if (do_pop) begin
      level_d = level_q - LW'(1);
      if (level_q == LW'(1)) begin
        top_addr_d = '0;
        top_cnt_d  = '0;
        top_type_d = '0;
      end else begin
        top_addr_d = rd_data[EW-1 -: AW];
        top_cnt_d  = rd_data[CW+1 -: CW];
        top_type_d = rd_data[1:0];
      end
    end else if (do_wr) begin
      top_cnt_d = upd_counter;
    end
  end

  // State and sticky error registers; reset drops every context at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q    <= '0;
      top_addr_q <= '0;
      top_cnt_q  <= '0;
      top_type_q <= '0;
      err_ovf_q  <= 1'b0;
      err_udf_q  <= 1'b0;
      err_type_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      top_addr_q <= top_addr_d;
      top_cnt_q  <= top_cnt_d;
      top_type_q <= top_type_d;
      err_ovf_q  <= err_ovf_q | ovf_evt;
      err_udf_q  <= err_udf_q | udf_evt;
      err_type_q <= err_type_q | type_bad;
    end
  end

  assign top_valid   = has_top;
  assign top_addr    = has_top ? top_addr_q : '0;
  assign top_counter = has_top ? top_cnt_q  : '0;
  assign top_type    = has_top ? top_type_q : '0;
  assign full        = is_full;
  assign empty       = ~has_top;
  assign level       = level_q;
  assign err_ovf     = err_ovf_q;
  assign err_udf     = err_udf_q;
  assign err_type    = err_type_q;

endmodule

// File: tb/tb_loop_stack.sv
// ---------------------------------------------------------------------------
// tb_loop_stack
//   Directed table of per-cycle stimulus with hand-computed expected state
//   for loop_stack (DEPTH=4, AW=CW=16), followed by a hand-written sequence
//   showing that the outputs do not react to inputs before the clock edge.
// ---------------------------------------------------------------------------
module tb_loop_stack;

  typedef struct packed {
    logic        rst;
    logic        push;
    logic [15:0] paddr;
    logic [15:0] pcount;
    logic [1:0]  ptype;
    logic        upd;
    logic        taken;
    logic [15:0] ucnt;
    logic        brk;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] cnt;
    logic [1:0]  typ;
    logic [2:0]  lvl;
    logic        ovf;
    logic        udf;
    logic        terr;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t expect_o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, push, upd, upd_taken, brk;
  logic [15:0] push_addr, push_count, upd_counter;
  logic [1:0]  push_type;
  logic        top_valid, full, empty, err_ovf, err_udf, err_type;
  logic [15:0] top_addr, top_counter;
  logic [1:0]  top_type;
  logic [2:0]  level;

  int checks = 0;
  int passed = 0;
  vec_t vecs[$];

  loop_stack #(.DEPTH(4), .AW(16), .CW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_addr   (push_addr),
    .push_count  (push_count),
    .push_type   (push_type),
    .upd         (upd),
    .upd_taken   (upd_taken),
    .upd_counter (upd_counter),
    .brk         (brk),
    .top_valid   (top_valid),
    .top_addr    (top_addr),
    .top_counter (top_counter),
    .top_type    (top_type),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf),
    .err_type    (err_type)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  function automatic in_t mk_in(logic r, logic p, logic [15:0] a, logic [15:0] c,
                                logic [1:0] t, logic u, logic tk, logic [15:0] uc,
                                logic b);
    in_t s;
    s.rst = r; s.push = p; s.paddr = a; s.pcount = c; s.ptype = t;
    s.upd = u; s.taken = tk; s.ucnt = uc; s.brk = b;
    return s;
  endfunction

  function automatic out_t mk_out(logic v, logic [15:0] a, logic [15:0] c,
                                  logic [1:0] t, logic [2:0] l,
                                  logic o, logic ud, logic te);
    out_t e;
    e.valid = v; e.addr = a; e.cnt = c; e.typ = t; e.lvl = l;
    e.ovf = o; e.udf = ud; e.terr = te;
    return e;
  endfunction

  function automatic void add(in_t s, out_t e);
    vec_t v;
    v.stim = s;
    v.expect_o = e;
    vecs.push_back(v);
  endfunction

  // Drive one cycle's inputs on the falling edge, away from the sampling edge.
  task automatic applyStimulus(input in_t s);
    @(negedge clk);
    rst         = s.rst;
    push        = s.push;
    push_addr   = s.paddr;
    push_count  = s.pcount;
    push_type   = s.ptype;
    upd         = s.upd;
    upd_taken   = s.taken;
    upd_counter = s.ucnt;
    brk         = s.brk;
  endtask

  task automatic checkOutput(input string name, input int row,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s (row %0d): got 0x%0h, expected 0x%0h", name, row, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic checkAll(input int row, input out_t e);
    checkOutput("top_valid",   row, 32'(top_valid),   32'(e.valid));
    checkOutput("top_addr",    row, 32'(top_addr),    32'(e.addr));
    checkOutput("top_counter", row, 32'(top_counter), 32'(e.cnt));
    checkOutput("top_type",    row, 32'(top_type),    32'(e.typ));
    checkOutput("level",       row, 32'(level),       32'(e.lvl));
    checkOutput("full",        row, 32'(full),        32'(e.lvl == 3'd4));
    checkOutput("empty",       row, 32'(empty),       32'(e.lvl == 3'd0));
    checkOutput("err_ovf",     row, 32'(err_ovf),     32'(e.ovf));
    checkOutput("err_udf",     row, 32'(err_udf),     32'(e.udf));
    checkOutput("err_type",    row, 32'(err_type),    32'(e.terr));
  endtask

  initial begin
    in_t idle;
    idle = mk_in(0, 0, 16'h0, 16'h0, 2'b00, 0, 0, 16'h0, 0);
    rst = 1'b1; push = 1'b0; push_addr = '0; push_count = '0; push_type = '0;
    upd = 1'b0; upd_taken = 1'b0; upd_counter = '0; brk = 1'b0;

    //   rst push addr      count    type   upd tk  ucnt     brk   | valid addr cnt type lvl ovf udf terr
    add(mk_in(1,0,16'h0000,16'd0,2'b00,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));
    add(mk_in(0,1,16'h0040,16'd3,2'b00,0,0,16'd0,0),   mk_out(1,16'h0040,16'd3,2'b00,3'd1,0,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,1,16'd2,0),   mk_out(1,16'h0040,16'd2,2'b00,3'd1,0,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,1,16'd1,0),   mk_out(1,16'h0040,16'd1,2'b00,3'd1,0,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));
    // fill to four, overflow, pop+replace while full
    add(mk_in(0,1,16'h0100,16'd1,2'b01,0,0,16'd0,0),   mk_out(1,16'h0100,16'd1,2'b01,3'd1,0,0,0));
    add(mk_in(0,1,16'h0200,16'd2,2'b10,0,0,16'd0,0),   mk_out(1,16'h0200,16'd2,2'b10,3'd2,0,0,0));
    add(mk_in(0,1,16'h0300,16'd3,2'b00,0,0,16'd0,0),   mk_out(1,16'h0300,16'd3,2'b00,3'd3,0,0,0));
    add(mk_in(0,1,16'h0400,16'd4,2'b01,0,0,16'd0,0),   mk_out(1,16'h0400,16'd4,2'b01,3'd4,0,0,0));
    add(mk_in(0,1,16'h0500,16'd5,2'b00,0,0,16'd0,0),   mk_out(1,16'h0400,16'd4,2'b01,3'd4,1,0,0));
    add(mk_in(0,1,16'h0600,16'd9,2'b10,1,0,16'd0,0),   mk_out(1,16'h0600,16'd9,2'b10,3'd4,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,0,0,16'd0,1),   mk_out(1,16'h0300,16'd3,2'b00,3'd3,1,0,0));
    // write-back plus push: the written counter must reappear after the pop
    add(mk_in(0,1,16'h0700,16'd6,2'b01,1,1,16'd7,0),   mk_out(1,16'h0700,16'd6,2'b01,3'd4,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,0,0,16'd0,1),   mk_out(1,16'h0300,16'd7,2'b00,3'd3,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,0,0,16'd0,1),   mk_out(1,16'h0200,16'd2,2'b10,3'd2,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,1,16'hFFFF,0),mk_out(1,16'h0200,16'hFFFF,2'b10,3'd2,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,0,0,16'd0,1),   mk_out(1,16'h0100,16'd1,2'b01,3'd1,1,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,1,0,0));
    // underflow and invalid type on an empty stack
    add(mk_in(1,0,16'h0000,16'd0,2'b00,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,0,16'd0,1),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,1,0));
    add(mk_in(0,1,16'h0800,16'd5,2'b11,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,1,1));
    add(mk_in(0,1,16'h0900,16'd2,2'b00,1,1,16'h55,0),  mk_out(1,16'h0900,16'd2,2'b00,3'd1,0,1,1));
    // brk beats upd in the same cycle
    add(mk_in(1,0,16'h0000,16'd0,2'b00,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));
    add(mk_in(0,1,16'h0010,16'd5,2'b00,0,0,16'd0,0),   mk_out(1,16'h0010,16'd5,2'b00,3'd1,0,0,0));
    add(mk_in(0,1,16'h0020,16'd2,2'b00,0,0,16'd0,0),   mk_out(1,16'h0020,16'd2,2'b00,3'd2,0,0,0));
    add(mk_in(0,0,16'h0000,16'd0,2'b00,1,1,16'd1,1),   mk_out(1,16'h0010,16'd5,2'b00,3'd1,0,0,0));
    // zero count stored as one, invalid type leaves stack alone, then reset
    add(mk_in(0,1,16'h0030,16'd0,2'b01,0,0,16'd0,0),   mk_out(1,16'h0030,16'd1,2'b01,3'd2,0,0,0));
    add(mk_in(0,1,16'h0040,16'd1,2'b11,0,0,16'd0,0),   mk_out(1,16'h0030,16'd1,2'b01,3'd2,0,0,1));
    add(mk_in(1,0,16'h0000,16'd0,2'b00,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));
    // full, then pop+push raises no overflow; bad type while full is not ovf
    add(mk_in(0,1,16'h0001,16'd1,2'b00,0,0,16'd0,0),   mk_out(1,16'h0001,16'd1,2'b00,3'd1,0,0,0));
    add(mk_in(0,1,16'h0002,16'd2,2'b00,0,0,16'd0,0),   mk_out(1,16'h0002,16'd2,2'b00,3'd2,0,0,0));
    add(mk_in(0,1,16'h0003,16'd3,2'b00,0,0,16'd0,0),   mk_out(1,16'h0003,16'd3,2'b00,3'd3,0,0,0));
    add(mk_in(0,1,16'h0004,16'd4,2'b00,0,0,16'd0,0),   mk_out(1,16'h0004,16'd4,2'b00,3'd4,0,0,0));
    add(mk_in(0,1,16'h0005,16'd5,2'b10,0,0,16'd0,1),   mk_out(1,16'h0005,16'd5,2'b10,3'd4,0,0,0));
    add(mk_in(0,1,16'h0006,16'd6,2'b11,0,0,16'd0,0),   mk_out(1,16'h0005,16'd5,2'b10,3'd4,0,0,1));
    add(mk_in(1,0,16'h0000,16'd0,2'b00,0,0,16'd0,0),   mk_out(0,16'h0000,16'd0,2'b00,3'd0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stim);
      @(posedge clk);
      #1;
      checkAll(i, vecs[i].expect_o);
    end

    // Outputs must hold until the edge even with new requests already driven.
    applyStimulus(mk_in(0,1,16'h00A0,16'd4,2'b00,0,0,16'd0,0));
    @(posedge clk);
    #1;
    applyStimulus(mk_in(0,1,16'h00BB,16'd8,2'b10,0,0,16'd0,1));
    #2;
    checkOutput("pre_edge_addr",  100, 32'(top_addr),    32'h00A0);
    checkOutput("pre_edge_cnt",   100, 32'(top_counter), 32'd4);
    checkOutput("pre_edge_level", 100, 32'(level),       32'd1);
    @(posedge clk);
    #1;
    checkAll(101, mk_out(1,16'h00BB,16'd8,2'b10,3'd1,0,0,0));
    applyStimulus(idle);
    @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
